timer_ms_multi: RTL and testbench

Multi-channel millisecond timer, the parametrised successor to the single fixed-duration ms timer used in the receiver control path. It provides N_CH independent channels, each with a runtime-loaded duration in milliseconds, one-shot or periodic mode, retrigger and abort. Every channel has its own sub-millisecond prescaler, so expiry is cycle-exact relative to its start. Its consumers are receiver sequencing logic: blanking windows, dwell timers and periodic sample or report strobes.

---
 rtl/timer_ms_multi.sv | 103 ++++++++++
 tb/tb_timer_ms_multi.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/timer_ms_multi.sv
// rtl/timer_ms_multi.sv - multi-channel millisecond timer with per-channel prescaler
// Each channel runs its own sub-ms and ms counters; expiry is cycle-exact from start.
module timer_ms_multi #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int N_CH     = 4,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       start_i,
  input  logic [N_CH-1:0]       stop_i,
  input  logic [N_CH-1:0]       periodic_i,
  input  logic [N_CH*CNT_W-1:0] duration_i,
  output logic [N_CH-1:0]       busy_o,
  output logic [N_CH-1:0]       expire_o,
  output logic [N_CH-1:0]       done_o
);

  localparam int CYC   = CLK_FREQ / 1000;
  localparam int SUB_W = $clog2(CYC);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYC - 1);
  localparam logic [SUB_W-1:0] SUB_PRE  = SUB_W'(CYC - 2);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] RUNNING = 1'b1;

  genvar c;
  generate
    for (c = 0; c < N_CH; c++) begin : g_ch
      logic [0:0]       state;
      logic [CNT_W-1:0] dur;
      logic             mode;
      logic [SUB_W-1:0] sub;
      logic [CNT_W-1:0] ms;
      logic             expire_q;
      logic             done_q;

      logic [CNT_W-1:0] dur_in;
      logic             running;
      logic             accept;
      logic             last_ms;
      logic             wrap;
      logic             expiry;
      logic             pre_expiry;

      assign dur_in     = duration_i[c*CNT_W +: CNT_W];
      assign running    = (state == RUNNING);
      assign accept     = start_i[c] && !stop_i[c] && (dur_in != '0);
      assign last_ms    = (ms == dur - CNT_W'(1));
      assign wrap       = running && (sub == SUB_LAST);
      assign expiry     = wrap && last_ms;
      // The pulse is registered one cycle ahead so it lands on the expiry wrap cycle itself.
      assign pre_expiry = running && (sub == SUB_PRE) && last_ms;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state    <= IDLE;
          dur      <= '0;
          mode     <= 1'b0;
          sub      <= '0;
          ms       <= '0;
          expire_q <= 1'b0;
          done_q   <= 1'b0;
        end else begin
          // A stop or retrigger on the cycle before expiry discards that period's pulse.
          expire_q <= pre_expiry && !stop_i[c] && !accept;
          if (stop_i[c]) begin
            state  <= IDLE;
            sub    <= '0;
            ms     <= '0;
            done_q <= 1'b0;
          end else if (accept) begin
            state  <= RUNNING;
            dur    <= dur_in;
            mode   <= periodic_i[c];
            sub    <= '0;
            ms     <= '0;
            done_q <= 1'b0;
          end else if (running) begin
            if (wrap) begin
              sub <= '0;
              if (expiry) begin
                ms     <= '0;
                done_q <= 1'b1;
                if (!mode)
                  state <= IDLE;
              end else begin
                ms <= ms + CNT_W'(1);
              end
            end else begin
              sub <= sub + SUB_W'(1);
            end
          end
        end
      end

      assign busy_o[c]   = running;
      assign expire_o[c] = expire_q;
      assign done_o[c]   = done_q;
    end
  endgenerate

endmodule

// File: tb/tb_timer_ms_multi.sv
// tb/tb_timer_ms_multi.sv - directed bench for timer_ms_multi (CYC=4, 4 channels, 8-bit durations)
module tb_timer_ms_multi;

  logic        clk;
  logic        rst;
  logic [3:0]  start_i;
  logic [3:0]  stop_i;
  logic [3:0]  periodic_i;
  logic [31:0] duration_i;
  logic [3:0]  busy_o;
  logic [3:0]  expire_o;
  logic [3:0]  done_o;

  int vec;
  int errs;

  timer_ms_multi #(.CLK_FREQ(4000), .N_CH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .periodic_i (periodic_i),
    .duration_i (duration_i),
    .busy_o     (busy_o),
    .expire_o   (expire_o),
    .done_o     (done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_dur(input int ch, input logic [7:0] d);
    duration_i[ch*8 +: 8] = d;
  endtask

  initial begin
    vec = 0;
    errs = 0;
    rst = 1'b1;
    start_i = '0;
    stop_i = '0;
    periodic_i = '0;
    duration_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy_o), 32'h0);
    chk("reset expire", 32'(expire_o), 32'h0);
    chk("reset done", 32'(done_o), 32'h0);
    rst = 1'b0;

    // One-shot ch0, duration 3: expire in cycle 12.
    set_dur(0, 8'd3);
    start_i[0] = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      step();
      start_i[0] = 1'b0;
      chk($sformatf("oneshot expire t=%0d", t), 32'(expire_o[0]), 32'(t == 12));
      chk($sformatf("oneshot busy t=%0d", t), 32'(busy_o[0]), 32'(t <= 12));
      chk($sformatf("oneshot done t=%0d", t), 32'(done_o[0]), 32'(t >= 13));
    end

    // Periodic ch1, duration 2, stopped at cycle 30.
    set_dur(1, 8'd2);
    periodic_i[1] = 1'b1;
    start_i[1] = 1'b1;
    for (int t = 1; t <= 34; t++) begin
      step();
      start_i[1] = 1'b0;
      stop_i[1] = (t == 30);
      chk($sformatf("periodic expire t=%0d", t), 32'(expire_o[1]),
          32'(t == 8 || t == 16 || t == 24));
      chk($sformatf("periodic busy t=%0d", t), 32'(busy_o[1]), 32'(t <= 30));
      chk($sformatf("periodic done t=%0d", t), 32'(done_o[1]), 32'(t >= 9 && t <= 30));
    end
    stop_i[1] = 1'b0;
    periodic_i[1] = 1'b0;

    // Retrigger ch2: duration 5 at cycle 0, duration 1 at cycle 10.
    set_dur(2, 8'd5);
    start_i[2] = 1'b1;
    for (int t = 1; t <= 22; t++) begin
      step();
      start_i[2] = (t == 10);
      if (t == 10) set_dur(2, 8'd1);
      chk($sformatf("retrig expire t=%0d", t), 32'(expire_o[2]), 32'(t == 14));
      chk($sformatf("retrig busy t=%0d", t), 32'(busy_o[2]), 32'(t <= 14));
      chk($sformatf("retrig done t=%0d", t), 32'(done_o[2]), 32'(t >= 15));
    end

    // Duration 0 start is ignored.
    set_dur(3, 8'd0);
    start_i[3] = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      step();
      start_i[3] = 1'b0;
      chk($sformatf("dur0 busy t=%0d", t), 32'(busy_o[3]), 32'h0);
    end

    // Start together with stop leaves the channel idle.
    set_dur(3, 8'd4);
    start_i[3] = 1'b1;
    stop_i[3] = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      step();
      start_i[3] = 1'b0;
      stop_i[3] = 1'b0;
      chk($sformatf("startstop busy t=%0d", t), 32'(busy_o[3]), 32'h0);
    end

    // Start coincident with one-shot expiry on ch0 (duration 2, expiries at 8 and 16).
    set_dur(0, 8'd2);
    start_i[0] = 1'b1;
    for (int t = 1; t <= 17; t++) begin
      step();
      start_i[0] = (t == 8);
      chk($sformatf("coinc expire t=%0d", t), 32'(expire_o[0]), 32'(t == 8 || t == 16));
      chk($sformatf("coinc busy t=%0d", t), 32'(busy_o[0]), 32'(t <= 16));
      chk($sformatf("coinc done t=%0d", t), 32'(done_o[0]), 32'(t == 17));
    end

    // All four channels, durations 1..4, started together.
    for (int ch = 0; ch < 4; ch++) set_dur(ch, 8'(ch + 1));
    start_i = 4'hf;
    for (int t = 1; t <= 17; t++) begin
      step();
      start_i = 4'h0;
      chk($sformatf("indep expire t=%0d", t), 32'(expire_o),
          32'({t == 16, t == 12, t == 8, t == 4}));
      chk($sformatf("indep busy t=%0d", t), 32'(busy_o),
          32'({t <= 16, t <= 12, t <= 8, t <= 4}));
      chk($sformatf("indep done t=%0d", t), 32'(done_o),
          32'({t >= 17, t >= 13, t >= 9, t >= 5}));
    end

    // Asynchronous reset mid-operation at cycle 6.
    start_i = 4'hf;
    for (int t = 1; t <= 6; t++) begin
      step();
      start_i = 4'h0;
    end
    chk("prereset busy", 32'(busy_o), 32'he);
    chk("prereset done", 32'(done_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst busy", 32'(busy_o), 32'h0);
    chk("async rst expire", 32'(expire_o), 32'h0);
    chk("async rst done", 32'(done_o), 32'h0);
    step();
    rst = 1'b0;
    for (int t = 8; t <= 20; t++) begin
      step();
      chk($sformatf("postrst expire t=%0d", t), 32'(expire_o), 32'h0);
      chk($sformatf("postrst busy t=%0d", t), 32'(busy_o), 32'h0);
    end
    chk("postrst done", 32'(done_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
